xadc_drp_sequencer: RTL and testbench



---
 rtl/xadc_pkg.sv | 21 ++
 rtl/xadc_timeout.sv | 36 +++
 rtl/xadc_drp_sequencer.sv | 136 +++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sequencer.
// Control register bit layout and result words live here.
package xadc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_EOC  = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DRDY = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int START   = 0;
  localparam int DONE    = 1;
  localparam int ADDR_LO = 8;
  localparam int ADDR_HI = 14;

  localparam logic [31:0] ERR_WORD  = 32'h8000_0000;
  localparam logic [1:0]  CTRL_DONE = 2'b10;

endpackage

// File: rtl/xadc_timeout.sv
// Saturating wait counter; expired flags the last permitted
// waiting cycle so the caller can leave on that same edge.
module xadc_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Runs one DRP read per start request and writes the result and
// the done/start-clear word back to the XADC register block.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter bit USE_EOC = 1'b1,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] control_in,
  output logic [1:0]  control_int,
  output logic        we_int,
  output logic [31:0] data_out,
  output logic        we_data,
  output logic        busy,
  input  logic        eoc_in,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  state_t      state_q, state_d;
  logic        den_q, den_d;
  logic        we_q, we_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        busy_q, busy_d;
  logic        cnt_clr, cnt_en, expired, fin;

  logic unused_ctrl;
  assign unused_ctrl = ^{control_in[31:15], control_in[7:1]};

  xadc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    den_d   = 1'b0;
    we_d    = 1'b0;
    ctrl_d  = 2'b00;
    data_d  = data_q;
    daddr_d = daddr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (control_in[START]) begin
          daddr_d = control_in[ADDR_HI:ADDR_LO];
          if (USE_EOC) begin
            state_d = S_WAIT_EOC;
          end else begin
            state_d = S_ISSUE;
            den_d   = 1'b1;
          end
        end
      end
      S_WAIT_EOC: begin
        cnt_en = 1'b1;
        if (eoc_in) begin
          state_d = S_ISSUE;
          den_d   = 1'b1;
        end else if (expired) begin
          data_d = ERR_WORD;
          fin    = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT_DRDY;
      end
      S_WAIT_DRDY: begin
        cnt_en = 1'b1;
        // drdy wins over a simultaneous timeout
        if (drp_drdy) begin
          data_d = {16'h0000, drp_do};
          fin    = 1'b1;
        end else if (expired) begin
          data_d = ERR_WORD;
          fin    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_DONE;
      we_d    = 1'b1;
      ctrl_d  = CTRL_DONE;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      den_q   <= 1'b0;
      we_q    <= 1'b0;
      ctrl_q  <= 2'b00;
      data_q  <= '0;
      daddr_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      busy_q  <= busy_d;
    end
  end

  assign control_int = ctrl_q;
  assign we_int      = we_q;
  assign we_data     = we_q;
  assign data_out    = data_q;
  assign busy        = busy_q;
  assign drp_den     = den_q;
  assign drp_daddr   = daddr_q;
  assign drp_dwe     = 1'b0;
  assign drp_di      = '0;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: two instances (no-EOC, EOC) checked
// cycle by cycle against a transaction timeline model.
module tb_xadc_drp_sequencer;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [31:0] control_in [2];
  logic [1:0]  control_int [2];
  logic        we_int [2];
  logic [31:0] data_out [2];
  logic        we_data [2];
  logic        busy [2];
  logic        eoc_in [2];
  logic        drp_den [2];
  logic        drp_dwe [2];
  logic [6:0]  drp_daddr [2];
  logic [15:0] drp_di [2];
  logic [15:0] drp_do [2];
  logic        drp_drdy [2];

  logic [31:0] last_data [2];
  logic [6:0]  last_addr [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xadc_drp_sequencer #(.USE_EOC(1'b0), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst[0]), .control_in(control_in[0]),
    .control_int(control_int[0]), .we_int(we_int[0]),
    .data_out(data_out[0]), .we_data(we_data[0]), .busy(busy[0]),
    .eoc_in(eoc_in[0]), .drp_den(drp_den[0]), .drp_dwe(drp_dwe[0]),
    .drp_daddr(drp_daddr[0]), .drp_di(drp_di[0]),
    .drp_do(drp_do[0]), .drp_drdy(drp_drdy[0])
  );

  xadc_drp_sequencer #(.USE_EOC(1'b1), .TIMEOUT(32)) dut1 (
    .clk(clk), .rst(rst[1]), .control_in(control_in[1]),
    .control_int(control_int[1]), .we_int(we_int[1]),
    .data_out(data_out[1]), .we_data(we_data[1]), .busy(busy[1]),
    .eoc_in(eoc_in[1]), .drp_den(drp_den[1]), .drp_dwe(drp_dwe[1]),
    .drp_daddr(drp_daddr[1]), .drp_di(drp_di[1]),
    .drp_do(drp_do[1]), .drp_drdy(drp_drdy[1])
  );

  task automatic expect_eq(string tag, logic [31:0] got,
                           logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(int s, bit den_e, bit we_e,
                             logic [31:0] data_e, bit busy_e,
                             logic [6:0] addr_e);
    string p;
    p = $sformatf("d%0d@%0t", s, $time);
    expect_eq({p, " den"}, 32'(drp_den[s]), 32'(den_e));
    expect_eq({p, " we_int"}, 32'(we_int[s]), 32'(we_e));
    expect_eq({p, " we_data"}, 32'(we_data[s]), 32'(we_e));
    expect_eq({p, " ctrl"}, 32'(control_int[s]),
              we_e ? 32'd2 : 32'd0);
    expect_eq({p, " data"}, data_out[s], data_e);
    expect_eq({p, " busy"}, 32'(busy[s]), 32'(busy_e));
    expect_eq({p, " daddr"}, 32'(drp_daddr[s]), 32'(addr_e));
    expect_eq({p, " dwe_di"}, {15'h0, drp_dwe[s], drp_di[s]}, 32'h0);
  endtask

  // Expected timeline, relative to the cycle start is first seen:
  // den one cycle after start (or after eoc), write-back one cycle
  // after drdy, or after TIMEOUT waiting cycles with the error word.
  task automatic run_txn(int s, logic [6:0] addr, int eoc_dly,
                         int drdy_dly, logic [15:0] dval, bit rewrite);
    int to;
    int e, den, d, done;
    logic [31:0] exp;
    logic [6:0] a;
    to  = (s == 1) ? 32 : 16;
    e   = -1;
    den = -1;
    d   = -1;
    exp = 32'h8000_0000;
    if (s == 1) begin
      e = 1 + eoc_dly;
      if (e <= to) den = e + 1;
    end else begin
      den = 1;
    end
    if (den < 0) begin
      done = to + 1;
    end else if (drdy_dly >= 1 && drdy_dly <= to) begin
      d    = den + drdy_dly;
      done = d + 1;
      exp  = {16'h0000, dval};
    end else begin
      done = den + to + 1;
    end
    for (int c = 0; c <= done + 1; c++) begin
      @(negedge clk);
      check_cycle(s, c == den, c == done,
                  (c >= done) ? exp : last_data[s],
                  (c >= 1 && c <= done),
                  (c >= 1) ? addr : last_addr[s]);
      a = (rewrite && c >= 2) ? ~addr : addr;
      if (c <= done)
        control_in[s] = {16'h0, 1'($urandom), a, 7'h0, 1'b1};
      else
        control_in[s] = 32'h0000_0002;
      eoc_in[s]   = (s == 1) ? (c == e) : 1'($urandom);
      drp_drdy[s] = (c == d) ? 1'b1 :
                    ((c == 0 || c == done + 1) ? 1'($urandom) : 1'b0);
      drp_do[s]   = (c == d) ? dval : 16'($urandom);
    end
    last_data[s] = exp;
    last_addr[s] = addr;
  endtask

  task automatic run_reset_mid(int s, logic [6:0] addr);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0)
        check_cycle(s, 0, 0, last_data[s], 0, last_addr[s]);
      else if (c <= 3)
        check_cycle(s, c == 1, 0, last_data[s], 1, addr);
      else
        check_cycle(s, 0, 0, 32'h0, 0, 7'h0);
      control_in[s] = (c <= 3) ? {17'h0, addr, 8'h01} : 32'h0;
      rst[s]        = (c == 3);
      drp_drdy[s]   = (c == 4);
      drp_do[s]     = 16'($urandom);
    end
    last_data[s] = 32'h0;
    last_addr[s] = 7'h0;
  endtask

  initial begin
    int s, to, r, dd;
    for (int i = 0; i < 2; i++) begin
      rst[i]        = 1'b1;
      control_in[i] = 32'h0;
      eoc_in[i]     = 1'b0;
      drp_drdy[i]   = 1'b0;
      drp_do[i]     = 16'h0;
      last_data[i]  = 32'h0;
      last_addr[i]  = 7'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      control_in[i] = {17'h0, 7'h55, 8'h01};
      check_cycle(i, 0, 0, 32'h0, 0, 7'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_cycle(i, 0, 0, 32'h0, 0, 7'h0);
      rst[i]        = 1'b0;
      control_in[i] = 32'h0;
    end

    // idle noise: stray drdy/eoc with start clear
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check_cycle(i, 0, 0, 32'h0, 0, 7'h0);
        control_in[i] = $urandom & 32'hFFFF_FFFE;
        drp_drdy[i]   = 1'($urandom);
        eoc_in[i]     = 1'($urandom);
        drp_do[i]     = 16'($urandom);
      end
    end
    for (int i = 0; i < 2; i++) begin
      control_in[i] = 32'h0;
      eoc_in[i]     = 1'b0;
      drp_drdy[i]   = 1'b0;
    end

    run_txn(0, 7'h10, 0, 3, 16'hABC0, 0);
    run_txn(0, 7'h22, 0, 99, 16'h1234, 0);
    run_txn(1, 7'h03, 19, 2, 16'h5A5A, 0);
    run_txn(1, 7'h07, 99, 1, 16'h1111, 0);
    run_txn(0, 7'h31, 0, 5, 16'hBEEF, 1);
    run_txn(0, 7'h01, 0, 16, 16'hF00D, 0);
    run_txn(1, 7'h7F, 31, 32, 16'hCAFE, 0);
    run_reset_mid(0, 7'h44);
    run_txn(0, 7'h45, 0, 2, 16'h0F0F, 0);

    for (int n = 0; n < 24; n++) begin
      s  = int'($urandom_range(0, 1));
      to = (s == 1) ? 32 : 16;
      r  = int'($urandom_range(0, 3));
      case (r)
        0: dd = 1;
        1: dd = to;
        2: dd = to + 1;
        default: dd = int'($urandom_range(1, to));
      endcase
      run_txn(s, 7'($urandom), int'($urandom_range(0, to)), dd,
              16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
